// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera display path.
package camera_pkg;

  localparam int CAM_W_DEFAULT = 320;
  localparam int CAM_H_DEFAULT = 240;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef logic [23:0] rgb888_t;

  // Widen each channel by replicating its top bits into the new low bits,
  // so full-scale 565 maps to full-scale 888 and zero stays zero.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
  endfunction

endpackage

// File: rtl/camera_frame_reader_pipe_delay.sv
// Fixed-depth register chain used to keep side-band signals aligned with
// the BRAM read and colour-expansion pipeline.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift the word one stage per clock; reset flushes every stage to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= data;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign delayed = stages[DEPTH-1];

endmodule

// File: rtl/camera_frame_reader.sv
// Camera layer producer: reads RGB565 frames from a double-buffered BRAM,
// upscales them, expands to RGB888 and emits them aligned with the
// delayed screen timing. Also owns the tear-free bank swap with the writer.
module camera_frame_reader
  import camera_pkg::*;
#(
  parameter int CAM_W        = CAM_W_DEFAULT,
  parameter int CAM_H        = CAM_H_DEFAULT,
  parameter int SCALE_LOG2   = 1,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_W       = 18
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              active_draw_in,
  input  logic              new_frame_in,
  input  logic              mirror_in,
  input  logic              frame_ready_in,
  output logic              read_bank_out,
  output logic              bank_released_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [15:0]       mem_data_in,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              active_draw_out,
  output logic [23:0]       camera_pixel_out
);

  localparam int LAT         = BRAM_LATENCY + 2;
  localparam int FRAME_WORDS = CAM_W * CAM_H;
  localparam logic [31:0] X_LO = 32'(X0);
  localparam logic [31:0] X_HI = 32'(X0 + (CAM_W << SCALE_LOG2));
  localparam logic [31:0] Y_LO = 32'(Y0);
  localparam logic [31:0] Y_HI = 32'(Y0 + (CAM_H << SCALE_LOG2));

  logic              read_bank;
  logic              pending;
  logic              mirror_q;
  logic              swap;
  logic              bank_now;
  logic              in_win;
  logic              win_late;
  logic [31:0]       h_wide;
  logic [31:0]       v_wide;
  logic [ADDR_W-1:0] sx;
  logic [ADDR_W-1:0] sy;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr_next;
  logic [21:0]       timing_late;

  // A swap happens at frame start when the writer has a finished frame,
  // including one announced in this very cycle. The address logic uses the
  // post-swap bank so the first read of the new frame hits the new bank.
  assign swap     = new_frame_in && (pending || frame_ready_in);
  assign bank_now = swap ? ~read_bank : read_bank;

  // Window test is done on the raw counts before any subtraction so a
  // count left of/above the image can never wrap into the window.
  always_comb begin
    h_wide    = 32'(hcount_in);
    v_wide    = 32'(vcount_in);
    in_win    = active_draw_in &&
                (h_wide >= X_LO) && (h_wide < X_HI) &&
                (v_wide >= Y_LO) && (v_wide < Y_HI);
    sx        = ADDR_W'((h_wide - X_LO) >> SCALE_LOG2);
    sy        = ADDR_W'((v_wide - Y_LO) >> SCALE_LOG2);
    col       = mirror_q ? (ADDR_W'(CAM_W - 1) - sx) : sx;
    addr_next = (bank_now ? ADDR_W'(FRAME_WORDS) : '0) + sy * ADDR_W'(CAM_W) + col;
  end

  // Bank handshake and frame-synchronous mirror sampling.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      read_bank         <= 1'b0;
      pending           <= 1'b0;
      mirror_q          <= 1'b0;
      bank_released_out <= 1'b0;
    end else begin
      read_bank         <= bank_now;
      pending           <= swap ? 1'b0 : (pending || frame_ready_in);
      bank_released_out <= swap;
      if (new_frame_in) mirror_q <= mirror_in;
    end
  end

  assign read_bank_out = read_bank;

  // First pipeline stage: register the read address, holding it outside
  // the image so the BRAM is not toggled needlessly.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_addr_out <= '0;
    end else if (in_win) begin
      mem_addr_out <= addr_next;
    end
  end

  pipe_delay #(.WIDTH(22), .DEPTH(LAT)) timing_pipe (
    .clk     (clk_in),
    .rst     (rst_in),
    .data    ({hcount_in, vcount_in, active_draw_in}),
    .delayed (timing_late)
  );

  pipe_delay #(.WIDTH(1), .DEPTH(BRAM_LATENCY + 1)) win_pipe (
    .clk     (clk_in),
    .rst     (rst_in),
    .data    (in_win),
    .delayed (win_late)
  );

  assign {hcount_out, vcount_out, active_draw_out} = timing_late;

  // Final stage: expand the returned word, blanking pixels outside the image.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      camera_pixel_out <= '0;
    end else begin
      camera_pixel_out <= win_late ? rgb565_to_888(rgb565_t'(mem_data_in)) : 24'h000000;
    end
  end

endmodule
